// File: rtl/fp_arith_pkg.sv
`default_nettype none
// ============================================================================
// fp_arith_pkg : sizing helpers and parameter legality for the ripple adder
// Revision     : 1.0
// ============================================================================
package fp_arith_pkg;

  localparam int c_min_width  = 2;
  localparam int c_max_width  = 64;
  localparam int c_min_stages = 1;

  // Width of every chunk except the last one.
  function automatic int calc_cw(input int width, input int stages);
    if (stages < 1) return width;
    return (width + stages - 1) / stages;
  endfunction

  function automatic int calc_last_w(input int width, input int stages);
    return width - (stages - 1) * calc_cw(width, stages);
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (width >= c_min_width) && (width <= c_max_width) &&
           (stages >= c_min_stages) && (stages <= width) &&
           (calc_last_w(width, stages) > 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_addsub_pipe_chunk.sv
`default_nettype none
// ============================================================================
// rca_chunk : combinational W-bit ripple chain of full-adder cells
// Revision  : 1.0
// ============================================================================
module rca_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout    = w_c[W];
  assign msb_cin = w_c[W - 1];

endmodule
`default_nettype wire

// File: rtl/rca_addsub_pipe.sv
`default_nettype none
// ============================================================================
// rca_addsub_pipe : pipelined ripple-carry add/sub with valid/ready handshake
// Revision        : 1.0
// ============================================================================
module rca_addsub_pipe
  import fp_arith_pkg::*;
#(
  parameter int WIDTH  = 25,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int c_cw     = calc_cw(WIDTH, STAGES);
  localparam int c_last_w = calc_last_w(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "rca_addsub_pipe: illegal WIDTH/STAGES combination");
  end

  // Each stage carries the full operand/partial-sum words; the unused
  // chunks are trimmed away, leaving exactly the skew/de-skew registers.
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_m   [STAGES];
  logic             r_sub [STAGES];
  logic             r_v   [STAGES];
  logic             r_zero;
  logic             w_en;

  assign w_en     = ~r_v[STAGES-1] | out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int c_lo = k * c_cw;
    localparam int c_w  = (k == STAGES - 1) ? c_last_w : c_cw;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_s_next;
    logic [c_w-1:0]   w_chunk_sum;
    logic             w_cin;
    logic             w_sub;
    logic             w_v;
    logic             w_cout;
    logic             w_msbc;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + ~borrow.
      assign w_a   = in_a;
      assign w_b   = in_sub ? ~in_b : in_b;
      assign w_cin = in_sub ^ in_cin;
      assign w_s   = '0;
      assign w_sub = in_sub;
      assign w_v   = in_valid;
    end else begin : g_next
      assign w_a   = r_a[k-1];
      assign w_b   = r_b[k-1];
      assign w_cin = r_c[k-1];
      assign w_s   = r_s[k-1];
      assign w_sub = r_sub[k-1];
      assign w_v   = r_v[k-1];
    end

    rca_chunk #(
      .W(c_w)
    ) u_chunk (
      .a       (w_a[c_lo +: c_w]),
      .b       (w_b[c_lo +: c_w]),
      .cin     (w_cin),
      .sum     (w_chunk_sum),
      .cout    (w_cout),
      .msb_cin (w_msbc)
    );

    always_comb begin
      w_s_next                = w_s;
      w_s_next[c_lo +: c_w]   = w_chunk_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_m[k]   <= 1'b0;
        r_sub[k] <= 1'b0;
      end else if (w_en) begin
        r_v[k]   <= w_v;
        r_a[k]   <= w_a;
        r_b[k]   <= w_b;
        r_s[k]   <= w_s_next;
        r_c[k]   <= w_cout;
        r_m[k]   <= w_msbc;
        r_sub[k] <= w_sub;
      end
    end

    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_zero <= 1'b0;
        end else if (w_en) begin
          r_zero <= ~|w_s_next;
        end
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign out_sum   = r_s[STAGES-1];
  // Raw carry is inverted into a borrow for subtraction.
  assign out_cout  = r_sub[STAGES-1] ^ r_c[STAGES-1];
  assign out_ovf   = r_m[STAGES-1] ^ r_c[STAGES-1];
  assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_rca_addsub_pipe.sv
`default_nettype none
// ============================================================================
// tb_rca_addsub_pipe : scoreboard bench for the pipelined ripple add/sub
// Revision           : 1.0
// ============================================================================
module tb_rca_addsub_pipe;

  localparam int W = 25;
  localparam int S = 3;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic [7:0]   s_in_a = '0;
  logic [7:0]   s_in_b = '0;
  logic         s_in_cin = 1'b0;
  logic         s_in_sub = 1'b0;
  logic         s_out_valid;
  logic         s_out_ready = 1'b1;
  logic [7:0]   s_out_sum;
  logic         s_out_cout;
  logic         s_out_ovf;
  logic         s_out_zero;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rca_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  rca_addsub_pipe #(.WIDTH(8), .STAGES(1)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf), .out_zero(s_out_zero)
  );

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce modulo 2^W.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint lc = cin ? 64'sd1 : 64'sd0;
    longint full, sa, sb, r;
    longint half = 64'sd1 <<< (W - 1);
    full   = sub ? (ua - ub - lc) : (ua + ub + lc);
    e.sum  = full[W-1:0];
    e.cout = sub ? (full < 0) : full[W];
    sa     = a[W-1] ? ua - 2 * half : ua;
    sb     = b[W-1] ? ub - 2 * half : ub;
    r      = sub ? (sa - sb - lc) : (sa + sb + lc);
    e.ovf  = (r > half - 1) || (r < -half);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // Entered and left at posedge+1; pushes the expectation once accepted.
  task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input exp_t e);
    bit acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) q.push_back(e);
    else begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected acceptance");
    end
  endtask

  task automatic send_rand();
    bit [31:0]    ra = $urandom();
    bit [31:0]    rb = $urandom();
    bit [31:0]    rc = $urandom();
    logic [W-1:0] a = ra[W-1:0];
    logic [W-1:0] b = rb[W-1:0];
    send_exp(a, b, rc[0], rc[1], model(a, b, rc[0], rc[1]));
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_pending", q.size(), 0);
  endtask

  exp_t held;
  bit   hold_pend = 1'b0;

  always @(negedge clk) begin : p_mon
    exp_t e;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      check("in_ready", in_ready, (!out_valid || out_ready));
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", out_sum, held.sum);
        check("hold_cout", out_cout, held.cout);
        check("hold_ovf", out_ovf, held.ovf);
        check("hold_zero", out_zero, held.zero);
      end
      hold_pend = out_valid && !out_ready;
      if (hold_pend) held = '{out_sum, out_cout, out_ovf, out_zero};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_output: got beat sum=0x%0h, expected none", out_sum);
        end else begin
          e = q.pop_front();
          check("sum", out_sum, e.sum);
          check("cout", out_cout, e.cout);
          check("ovf", out_ovf, e.ovf);
          check("zero", out_zero, e.zero);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_small_valid", s_out_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Add with wrap, plus latency measurement.
    send_exp(25'h1FFFFFF, 25'h0000001, 1'b0, 1'b0, '{25'h0000000, 1'b1, 1'b0, 1'b1});
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    check("latency", lat, S - 1);
    @(posedge clk); #1;
    drain();

    // Subtract with borrow, then with borrow-in.
    send_exp(25'd5, 25'd7, 1'b0, 1'b1, '{25'h1FFFFFE, 1'b1, 1'b0, 1'b0});
    send_exp(25'd7, 25'd5, 1'b1, 1'b1, '{25'h0000001, 1'b0, 1'b0, 1'b0});
    drain();

    // Signed overflow; carry crosses both chunk boundaries.
    send_exp(25'h0FFFFFF, 25'h0000001, 1'b0, 1'b0, '{25'h1000000, 1'b0, 1'b1, 1'b0});
    drain();

    // Ten back-to-back beats with a four-cycle stall mid-stream.
    fork
      for (int i = 0; i < 10; i++) send_rand();
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic under random backpressure.
    fork
      for (int i = 0; i < 30; i++) send_rand();
      begin
        repeat (60) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight, one of them already at the output.
    send_rand();
    send_rand();
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_cout", out_cout, 0);
    check("mid_rst_ovf", out_ovf, 0);
    check("mid_rst_zero", out_zero, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    @(posedge clk); #1;
    send_rand();
    drain();

    // WIDTH=8, STAGES=1 variant: one-cycle latency.
    s_in_valid = 1'b1; s_in_a = 8'hFF; s_in_b = 8'h01;
    @(negedge clk);
    check("small_in_ready", s_in_ready, 1);
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    @(negedge clk);
    check("small_valid", s_out_valid, 1);
    check("small_sum", s_out_sum, 8'h00);
    check("small_cout", s_out_cout, 1);
    check("small_ovf", s_out_ovf, 0);
    check("small_zero", s_out_zero, 1);
    @(negedge clk);
    check("small_valid_drop", s_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rca_addsub_pipe.md
# rca_addsub_pipe

Parametrised, pipelined ripple-carry adder/subtractor for the IEEE754 add/sub datapath. It generalises the fixed 8/9/10/25/26-bit ripple adders to any width, adds a subtract mode, carry/borrow-in and signed-overflow/zero flags, and cuts the carry chain into registered segments. It sits between the alignment shifter and the normaliser and uses a valid/ready handshake on both sides.

## Interface
- WIDTH, 25: operand and result width; legal range is 2..64.
- STAGES, 3: number of carry-chain segments, which equals latency in cycles; legal range is 1..WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in in add mode, borrow-in in sub mode.
- in_sub  in  1  0 selects A+B+cin; 1 selects A−B−cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry-out in add mode, borrow-out in sub mode.
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  high when out_sum == 0.

## Operation
- **Operand conditioning:** in sub mode the block uses B' = ~in_b and c0 = ~in_cin. In add mode it uses B' = in_b and c0 = in_cin.
- **Chunking:** CW = ceil(WIDTH/STAGES). Chunks 0..STAGES−2 are CW bits wide. The last chunk is WIDTH−(STAGES−1)·CW bits and must be >0; an elaboration check rejects any other parameter combination.
- **Per-stage computation:** stage k adds chunk k of A and B' to the carry registered by stage k−1 (c0 for k=0). It registers:
  - its chunk sum,
  - the carry out of the chunk,
  - the carry into the chunk's MSB, when k is the last stage.
- **Skew and de-skew:** operand chunks for stage k pass through k skew registers. Lower result chunks are delayed so all chunks emerge aligned.
- **Flags:**
  - raw carry = carry out of the MSB.
  - out_cout = raw carry in add mode, ~raw carry in sub mode.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = ~|out_sum, registered with the last stage.
- **Pipeline control:**
  - A valid bit travels with each stage.
  - Global advance: en = ~out_valid | out_ready.
  - in_ready = en.
  - A beat is accepted when in_valid & in_ready.
  - When en=0, every register holds, including skew registers.
  - Bubbles are permitted; each stage's valid bit records whether that stage holds a beat.
- **Ordering:** results leave in acceptance order. No beat is dropped or duplicated.
- **Reset:**
  - Asserting rst_n low clears all valid bits and data/flag registers to 0, including mid-operation.
  - Beats in flight are discarded.
  - No output appears after reset is released until new beats are accepted.

## Timing
- Output values while in reset and immediately after it: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0. in_ready=1, since it is combinational from out_valid.
- **Latency:** a beat accepted on edge T presents out_valid=1 after edge T+STAGES−1, so it is sampled on edge T+STAGES. STAGES=1 gives one registered cycle.
- **Throughput:** one beat per cycle while out_ready=1.
- **Holding under backpressure:** out_valid=1 with out_ready=0 freezes the whole pipe and drives in_ready=0 in the same cycle. Output values must remain stable until the handshake completes.
- **Simultaneous accept and emit:** a beat may be accepted and another emitted on the same edge.
- **Critical path:** one chunk, CW full-adder cells, plus the registers.

## Structure
- Shared package fp_arith_pkg, containing:
  - the function that computes CW from WIDTH and STAGES,
  - the function that computes the last-chunk width,
  - the WIDTH/STAGES legality check constants.
- Sub-module rca_chunk (parameter W):
  - purely combinational W-bit ripple chain of full-adder cells;
  - ports a, b, cin, sum, cout, msb_cin;
  - instantiated once per stage under generate.
- The top module contains the skew/de-skew registers, the valid chain and the flag logic.

## Test plan
All scenarios use WIDTH=25, STAGES=3 (chunks 9/9/7) unless noted.
1. **Add with wrap:** a=0x1FFFFFF, b=0x0000001, cin=0, sub=0 → sum=0x0000000, cout=1, ovf=0, zero=1; out_valid rises 3 cycles after accept.
2. **Subtract with borrow:** a=5, b=7, cin=0, sub=1 → sum=0x1FFFFFE, cout=1, ovf=0, zero=0. Then a=7, b=5, cin=1, sub=1 → sum=1, cout=0.
3. **Signed overflow:** a=0x0FFFFFF, b=1, add → sum=0x1000000, ovf=1, cout=0. Carry must cross both chunk boundaries.
4. **Backpressure:**
   - Stimulus: stream of 10 back-to-back random beats; out_ready held 0 for 4 cycles mid-stream.
   - Required: in_ready drops the same cycle; outputs stay stable; all 10 results match a reference model, in order, with no loss or duplication.
5. **Reset mid-operation:**
   - Stimulus: with 2 beats in flight, pulse rst_n low asynchronously between edges.
   - Required: out_valid=0 and all outputs 0 immediately; no output after release until new input is accepted.
6. **Parameter variant WIDTH=8, STAGES=1:** 0xFF+0x01 → sum=0x00, cout=1, zero=1, latency 1. An illegal combination (WIDTH=8, STAGES=7) must fail elaboration.
